// File: rtl/mips_md_pkg.sv
// ---------------------------------------------------------------------------
// mips_md_pkg
// Shared definitions for the multiply/divide unit and the stall unit:
//   - md_op_e       : E-stage MD_Op encodings
//   - MD_START_*    : Start flag encodings seen by the stall unit
//   - MD_*_DEF      : default Busy durations for mult/multu and div/divu
//   - md_is_arith() : op launches a multi-cycle multiply/divide
//   - md_start_code(): Start encoding for a launched op
// ---------------------------------------------------------------------------
package mips_md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_NONE7 = 3'd7
    } md_op_e;

    // Start encodings; 2'b11 is reserved and never driven.
    localparam logic [1:0] MD_START_NONE = 2'b00;
    localparam logic [1:0] MD_START_MUL  = 2'b01;
    localparam logic [1:0] MD_START_DIV  = 2'b10;

    localparam int unsigned MD_MUL_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF = 10;

    function automatic logic md_is_arith(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic [1:0] md_start_code(input md_op_e op);
        logic [1:0] code;
        code = MD_START_NONE;
        case (op)
            MD_MULT, MD_MULTU: code = MD_START_MUL;
            MD_DIV,  MD_DIVU:  code = MD_START_DIV;
            default:           code = MD_START_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/md_arith.sv
// ---------------------------------------------------------------------------
// md_arith
// Combinational HI/LO result for the latched multiply/divide operation.
//   op_i : latched MD_Op (only mult/multu/div/divu produce a result)
//   a_i  : latched rs operand (multiplicand / dividend)
//   b_i  : latched rt operand (multiplier / divisor)
//   hi_o : product[63:32] or remainder
//   lo_o : product[31:0]  or quotient
// Divide by zero yields LO=0xFFFFFFFF, HI=dividend (signed and unsigned).
// ---------------------------------------------------------------------------
import mips_md_pkg::*;

module md_arith (
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] qmag;
    logic [31:0] rmag;
    logic        q_neg;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide works on magnitudes so 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a separate overflow path.
    assign mag_a = a_i[31] ? (32'd0 - a_i) : a_i;
    assign mag_b = b_i[31] ? (32'd0 - b_i) : b_i;
    assign q_neg = a_i[31] ^ b_i[31];

    always_comb begin
        qmag = '0;
        rmag = '0;
        if (mag_b != 32'd0) begin
            qmag = mag_a / mag_b;
            rmag = mag_a % mag_b;
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        case (md_op_e'(op_i))
            MD_MULT: begin
                hi_o = prod_s[63:32];
                lo_o = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_o = prod_u[63:32];
                lo_o = prod_u[31:0];
            end
            MD_DIV: begin
                if (b_i == 32'd0) begin
                    hi_o = a_i;
                    lo_o = '1;
                end else begin
                    lo_o = q_neg    ? (32'd0 - qmag) : qmag;
                    hi_o = a_i[31]  ? (32'd0 - rmag) : rmag;
                end
            end
            MD_DIVU: begin
                if (b_i == 32'd0) begin
                    hi_o = a_i;
                    lo_o = '1;
                end else begin
                    lo_o = a_i / b_i;
                    hi_o = a_i % b_i;
                end
            end
            default: begin
                hi_o = '0;
                lo_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
// Multi-cycle MIPS multiply/divide sequencer with HI/LO registers.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   MD_Op  : E-stage op (0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 none)
//   A, B   : forwarded rs / rt operands
//   Cancel : exception flush of the E-stage instruction
//   Start  : combinational launch flag (00 none, 01 multiply, 10 divide)
//   Busy   : registered, high while an operation is in flight
//   HI, LO : architectural HI/LO registers
// Parameters MUL_CYCLES / DIV_CYCLES set the Busy duration (minimum 1).
// Optional feature macro MD_SEQUENCER_CANCEL_EN: when defined, Cancel in IDLE
// suppresses accept, Start and mthi/mtlo writes; otherwise Cancel is ignored.
// ---------------------------------------------------------------------------
import mips_md_pkg::*;

module md_sequencer #(
    parameter int unsigned MUL_CYCLES = MD_MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MD_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic [1:0]  Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned MUL_N   = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
    localparam int unsigned DIV_N   = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;
    localparam int unsigned CNT_MAX = (MUL_N > DIV_N) ? MUL_N : DIV_N;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [2:0]       op_q,    op_d;

    logic        cancel_eff;
    md_op_e      op_in;
    logic        idle;
    logic        accept;
    logic        done;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

`ifdef MD_SEQUENCER_CANCEL_EN
    assign cancel_eff = Cancel;
`else
    logic unused_cancel;
    assign unused_cancel = Cancel;
    assign cancel_eff    = 1'b0;
`endif

    md_arith u_arith (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_o (res_hi),
        .lo_o (res_lo)
    );

    assign op_in  = md_op_e'(MD_Op);
    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && !cancel_eff && md_is_arith(op_in);
    // Counter holds N in the first Busy cycle, so 1 marks the last one.
    assign done   = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

    always_comb begin
        Start = MD_START_NONE;
        if (!reset && accept) begin
            Start = md_start_code(op_in);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = MD_Op;
                    cnt_d   = ((op_in == MD_MULT) || (op_in == MD_MULTU)) ?
                              CNT_W'(MUL_N) : CNT_W'(DIV_N);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else if (!cancel_eff && (op_in == MD_MTHI)) begin
                    hi_d = A;
                end else if (!cancel_eff && (op_in == MD_MTLO)) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                // Any MD_Op and Cancel are ignored here; the op always commits.
                cnt_d = cnt_q - CNT_W'(1);
                if (done) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
// Self-checking bench for md_sequencer: directed scenarios followed by
// randomized ops, all compared against a transaction-level reference model.
// Honours MD_SEQUENCER_CANCEL_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

    localparam int unsigned MUL_N = 5;
    localparam int unsigned DIV_N = 10;

`ifdef MD_SEQUENCER_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  MD_Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic [1:0]  Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    md_sequencer #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .MD_Op  (MD_Op),
        .A      (A),
        .B      (B),
        .Cancel (Cancel),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {HI,LO} of a multiply/divide from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int                ia, ib;
        longint            sa, sb, q, r;
        longint unsigned   ua, ub;
        logic [63:0]       res, qv, rv;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = a;  ub = b;
        res = '0;
        case (op)
            3'd1: res = sa * sb;
            3'd2: res = ua * ub;
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == 3'd3) begin
                        q = sa / sb; r = sa % sb;
                        qv = q; rv = r;
                    end else begin
                        qv = ua / ub; rv = ua % ub;
                    end
                    res = {rv[31:0], qv[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // One clock cycle: drive inputs, check all outputs mid-cycle, advance model.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic r);
        logic [1:0] e_start;
        bit         ce, acc;
        MD_Op = op; A = a; B = b; Cancel = c; reset = r;
        ce  = CANCEL_EN && c;
        acc = (m_left == 0) && !ce && (op >= 3'd1) && (op <= 3'd4);
        e_start = (r || !acc) ? 2'b00 : ((op <= 3'd2) ? 2'b01 : 2'b10);
        @(negedge clk);
        check("start", {62'd0, Start}, {62'd0, e_start});
        check("busy",  {63'd0, Busy},  {63'd0, (m_left > 0)});
        check("hi",    {32'd0, HI},    {32'd0, m_hi});
        check("lo",    {32'd0, LO},    {32'd0, m_lo});
        @(posedge clk);
        if (r) begin
            m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (acc) begin
            {p_hi, p_lo} = ref_result(op, a, b);
            m_left = (op <= 3'd2) ? MUL_N : DIV_N;
        end else if (!ce && op == 3'd5) begin
            m_hi = a;
        end else if (!ce && op == 3'd6) begin
            m_lo = a;
        end
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [2:0] rop;
        MD_Op = '0; A = '0; B = '0; Cancel = 1'b0; reset = 1'b1;
        m_left = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_hi",   {32'd0, HI},   64'd0);
        check("rst_lo",   {32'd0, LO},   64'd0);
        step(3'd1, 32'h1234_5678, 32'h9, 1'b0, 1'b1);   // Start must stay 00 under reset

        // Signed multiply: -1 * 2
        step(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle_steps(MUL_N);
        check("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, LO}, 64'hFFFF_FFFE);

        // Unsigned multiply, back-to-back with the previous completion
        step(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle_steps(MUL_N);
        check("multu_hi", {32'd0, HI}, 64'h0000_0001);
        check("multu_lo", {32'd0, LO}, 64'hFFFF_FFFE);

        // Signed divide: -7 / 2
        step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle_steps(DIV_N);
        check("div_lo", {32'd0, LO}, 64'hFFFF_FFFD);
        check("div_hi", {32'd0, HI}, 64'hFFFF_FFFF);

        // Unsigned divide by zero with an mthi presented in Busy cycle 3
        step(3'd4, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        idle_steps(2);
        step(3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0);
        check("mthi_ignored", {32'd0, HI}, 64'hFFFF_FFFF);
        idle_steps(DIV_N - 3);
        check("divu0_lo", {32'd0, LO}, 64'hFFFF_FFFF);
        check("divu0_hi", {32'd0, HI}, 64'h0000_1234);

        // Signed overflow and signed divide by zero
        step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle_steps(DIV_N);
        check("ovf_lo", {32'd0, LO}, 64'h8000_0000);
        check("ovf_hi", {32'd0, HI}, 64'd0);
        step(3'd3, 32'h8765_4321, 32'd0, 1'b0, 1'b0);
        idle_steps(DIV_N);
        check("div0_lo", {32'd0, LO}, 64'hFFFF_FFFF);
        check("div0_hi", {32'd0, HI}, 64'h8765_4321);

        // Reset in Busy cycle 4 of a divide, then mtlo
        step(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idle_steps(3);
        step(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("rstmid_busy", {63'd0, Busy}, 64'd0);
        check("rstmid_hi",   {32'd0, HI},   64'd0);
        check("rstmid_lo",   {32'd0, LO},   64'd0);
        step(3'd6, 32'h55, 32'd0, 1'b0, 1'b0);
        check("mtlo_lo", {32'd0, LO}, 64'h55);

        // mult with Cancel in IDLE
        step(3'd1, 32'd3, 32'd4, 1'b1, 1'b0);
        check("cancel_busy", {63'd0, Busy}, CANCEL_EN ? 64'd0 : 64'd1);
        idle_steps(MUL_N);
        check("cancel_lo", {32'd0, LO}, CANCEL_EN ? 64'h55 : 64'd12);
        check("cancel_hi", {32'd0, HI}, 64'd0);

        // Cancel during RUN never aborts the accepted op
        step(3'd2, 32'd6, 32'd7, 1'b0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle_steps(MUL_N - 1);
        check("runcancel_lo", {32'd0, LO}, 64'd42);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rop = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 7)) : 3'd0;
            step(rop, rand_operand(), rand_operand(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end
        idle_steps(DIV_N + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter MUL_CYCLES, default 5, SHALL set the Busy duration of mult/multu.
REQ-003 Parameter DIV_CYCLES, default 10, SHALL set the Busy duration of div/divu.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 MD_Op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
REQ-007 A  in  32  rs operand, forwarded value.
REQ-008 B  in  32  rt operand, forwarded value.
REQ-009 Cancel  in  1  exception flush of the E-stage instruction.
REQ-010 Start  out  2  combinational launch flag to the stall unit: 00 none, 01 multiply, 10 divide, 11 never driven.
REQ-011 Busy  out  1  registered; high while an operation is in flight.
REQ-012 HI  out  32  HI register.
REQ-013 LO  out  32  LO register.

Function
REQ-014 States SHALL be IDLE and RUN. Reset SHALL enter IDLE.
REQ-015 Accept: in IDLE, MD_Op in 1..4 and Cancel effectively low SHALL accept the op at that edge.
REQ-016 In the accept cycle, Start SHALL be 01 for mult/multu and 10 for div/divu. Start SHALL be 00 in all other cycles, including all RUN cycles.
REQ-017 At accept, the block SHALL latch A, B and the op, load counter = MUL_CYCLES or DIV_CYCLES, and go to RUN.
REQ-018 In RUN, Busy SHALL be 1, and the counter SHALL decrement once per cycle.
REQ-019 Timing for an op accepted in cycle k: Busy=1 in cycles k+1..k+N.
REQ-020 At the edge ending cycle k+N, the block SHALL write HI/LO, clear Busy and return to IDLE. The new HI/LO SHALL be visible from cycle k+N+1.
REQ-021 mult: {HI,LO} SHALL be the signed 64-bit product of A and B. multu: the unsigned 64-bit product.
REQ-022 div: LO SHALL be the signed quotient truncated toward zero; HI SHALL be the remainder with the sign of the dividend. divu: unsigned quotient and remainder.
REQ-023 Divide by zero (B=0): LO SHALL be 0xFFFFFFFF and HI SHALL be A, signed and unsigned.
REQ-024 Signed overflow (0x80000000 / -1): LO SHALL be 0x80000000 and HI SHALL be 0.
REQ-025 mthi/mtlo in IDLE SHALL write A into HI/LO at that edge. They SHALL NOT drive Start or Busy.
REQ-026 Any MD_Op presented during RUN, including mthi/mtlo, SHALL be ignored; HI/LO SHALL change only at completion.
REQ-027 HI/LO SHALL be readable combinationally every cycle; during RUN they SHALL hold their pre-op values.
REQ-028 Back-to-back: a new op MAY be accepted in cycle k+N+1, the first cycle after completion.

Reset
REQ-029 Reset SHALL force IDLE, Busy=0, counter=0, HI=0 and LO=0 at the next edge, including mid-operation. The in-flight result SHALL be discarded.
REQ-030 Start SHALL be 00 in any cycle where reset is high.

Configuration
REQ-031 Macro MD_SEQUENCER_CANCEL_EN: when defined, Cancel=1 in IDLE SHALL suppress accept, Start and mthi/mtlo writes.
REQ-032 When MD_SEQUENCER_CANCEL_EN is defined, Cancel during RUN SHALL have no effect; an op that has been accepted always commits.
REQ-033 When MD_SEQUENCER_CANCEL_EN is undefined, the Cancel port SHALL remain present but SHALL be ignored.

Structure
REQ-034 Shared package mips_md_pkg SHALL hold the MD_Op encodings, the Start encodings, and the MUL_CYCLES/DIV_CYCLES defaults. The stall unit SHALL import the same package.
REQ-035 One sub-module, md_arith, SHALL hold the combinational 64-bit product and the quotient/remainder, including the divide-by-zero and overflow rules. The FSM, counter and HI/LO registers SHALL stay in md_sequencer.

Verification
REQ-036 mult A=0xFFFFFFFF B=2 accepted in cycle 0 -> Start=01 in cycle 0; Busy=1 in cycles 1..5; from cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-037 multu A=0xFFFFFFFF B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
REQ-038 div A=0xFFFFFFF9 (-7) B=2 -> Start=10; Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-039 divu A=0x00001234 B=0 -> LO=0xFFFFFFFF, HI=0x00001234; a following mthi A=0xA5A5A5A5 presented in Busy cycle 3 -> ignored, HI stays at the pre-op value until completion.
REQ-040 Reset asserted in Busy cycle 4 of a div -> next cycle Busy=0, HI=LO=0; mtlo A=0x55 in the following cycle -> LO=0x55 in the next cycle.
REQ-041 With MD_SEQUENCER_CANCEL_EN: mult plus Cancel=1 in IDLE -> Start=00, Busy stays 0, HI/LO unchanged. Without the macro: the same stimulus -> normal 5-cycle multiply.
